// File: rtl/imem_stream_loader_if.sv
// Byte-stream and instruction-memory write-side signal bundle for the loader.
// Latency: none (pure wiring).
// Backpressure: s_valid/s_ready handshake; the write port has no backpressure.
// Ports: start, s_valid, s_ready, s_data (stream side); imem_we, imem_addr,
//   imem_wdata (memory side); cpu_hold, busy, done, error, words_loaded (status).
interface imem_stream_loader_if #(
  parameter int INSTR_ADDRESS_WIDTH = 6,
  parameter int CPU_DATA_WIDTH      = 32
);
  logic                           start;
  logic                           s_valid;
  logic                           s_ready;
  logic [7:0]                     s_data;
  logic                           imem_we;
  logic [INSTR_ADDRESS_WIDTH-1:0] imem_addr;
  logic [CPU_DATA_WIDTH-1:0]      imem_wdata;
  logic                           cpu_hold;
  logic                           busy;
  logic                           done;
  logic                           error;
  logic [15:0]                    words_loaded;

  // Loader side.
  modport slave (
    input  start, s_valid, s_data,
    output s_ready, imem_we, imem_addr, imem_wdata,
           cpu_hold, busy, done, error, words_loaded
  );

  // Host / byte-source side.
  modport master (
    output start, s_valid, s_data,
    input  s_ready, imem_we, imem_addr, imem_wdata,
           cpu_hold, busy, done, error, words_loaded
  );
endinterface

// File: rtl/imem_stream_loader.sv
// Loads a framed byte stream (LEN_LO, LEN_HI, N x 4 bytes LSB first, CSUM) into imem.
// Latency: one imem write the cycle after each word's 4th byte; done the cycle after CSUM.
// Backpressure: s_ready high in every receiving state (one byte/cycle), low in IDLE/DONE.
// Ports: clk, rst (async active-high); bus (imem_stream_loader_if.slave) carrying the
//   stream handshake, the imem write port and the cpu_hold/busy/done/error/words_loaded status.
module imem_stream_loader #(
  parameter int INSTR_ADDRESS_WIDTH = 6,
  parameter int CPU_DATA_WIDTH      = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  imem_stream_loader_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE, LEN_LO, LEN_HI, DATA, CSUM, DONE
  } state_t;

  // Memory depth as a 17-bit value so word indices up to 65535 compare cleanly.
  localparam logic [16:0] DEPTH = 17'd1 << INSTR_ADDRESS_WIDTH;

  state_t                    state, state_nxt;
  logic [7:0]                len_lo;
  logic [15:0]               len;
  logic [15:0]               word_idx;
  logic [1:0]                byte_cnt;
  logic [7:0]                csum;
  logic [CPU_DATA_WIDTH-1:0] wbuf;
  logic                      ready;
  logic                      accept;

  assign ready  = (state == LEN_LO) || (state == LEN_HI) ||
                  (state == DATA)   || (state == CSUM);
  assign accept = bus.s_valid && ready;

  assign bus.s_ready  = ready;
  assign bus.cpu_hold = (state != IDLE);
  assign bus.busy     = (state != IDLE);
  assign bus.done     = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (bus.start) state_nxt = LEN_LO;
      LEN_LO: if (accept)    state_nxt = LEN_HI;
      LEN_HI: if (accept)    state_nxt = ({bus.s_data, len_lo} == 16'd0) ? CSUM : DATA;
      // Leave DATA on the last byte of the last word.
      DATA:   if (accept && (byte_cnt == 2'd3) && ((word_idx + 16'd1) == len))
                state_nxt = CSUM;
      CSUM:   if (accept)    state_nxt = DONE;
      DONE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_lo           <= '0;
      len              <= '0;
      word_idx         <= '0;
      byte_cnt         <= '0;
      csum             <= '0;
      wbuf             <= '0;
      bus.imem_we      <= 1'b0;
      bus.imem_addr    <= '0;
      bus.imem_wdata   <= '0;
      bus.error        <= 1'b0;
      bus.words_loaded <= '0;
    end else begin
      bus.imem_we <= 1'b0;
      if ((state == IDLE) && bus.start) begin
        bus.error        <= 1'b0;
        bus.words_loaded <= '0;
        csum             <= '0;
        byte_cnt         <= '0;
        word_idx         <= '0;
      end
      if (accept) begin
        case (state)
          LEN_LO: begin
            len_lo <= bus.s_data;
            csum   <= csum ^ bus.s_data;
          end
          LEN_HI: begin
            len  <= {bus.s_data, len_lo};
            csum <= csum ^ bus.s_data;
          end
          DATA: begin
            csum                 <= csum ^ bus.s_data;
            wbuf[8*byte_cnt +: 8] <= bus.s_data;
            byte_cnt             <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              word_idx <= word_idx + 16'd1;
              // Words past the end of memory are consumed but never written.
              if ({1'b0, word_idx} < DEPTH) begin
                bus.imem_we      <= 1'b1;
                bus.imem_addr    <= word_idx[INSTR_ADDRESS_WIDTH-1:0];
                bus.imem_wdata   <= {bus.s_data, wbuf[23:0]};
                bus.words_loaded <= bus.words_loaded + 16'd1;
              end else begin
                bus.error <= 1'b1;
              end
            end
          end
          CSUM: begin
            if (bus.s_data != csum) bus.error <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_stream_loader.sv
// Scoreboarded bench: directed frames push expected writes/done results into queues,
// a negedge monitor pops and compares whenever the loader writes or signals done.
// Run with a 4-word memory so the overflow case stays short.
module tb_imem_stream_loader;
  localparam int W = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  imem_stream_loader_if #(.INSTR_ADDRESS_WIDTH(W), .CPU_DATA_WIDTH(32)) bus();

  imem_stream_loader #(.INSTR_ADDRESS_WIDTH(W), .CPU_DATA_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct { logic [31:0] addr; logic [31:0] data; int wl; int idx; } wr_t;
  typedef struct { logic err; int wl; int idx; } dn_t;

  wr_t exp_w[$];
  dn_t exp_d[$];
  int  acc_cyc[64];
  int  cyc = 0;
  int  n_chk = 0;
  int  n_pass = 0;
  int  done_cnt = 0;
  int  done_cyc = 0;
  int  start_cyc = 0;
  int  ready_gaps = 0;
  bit  chk_idle = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  // Monitor / scoreboard.
  initial begin : monitor
    wr_t e;
    dn_t d;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (chk_idle) begin
          check("idle_after_done_busy", 32'(bus.busy), 32'd0);
          check("idle_after_done_hold", 32'(bus.cpu_hold), 32'd0);
          chk_idle = 0;
        end
        if (bus.busy && !bus.done && !bus.s_ready) ready_gaps++;
        if (bus.imem_we) begin
          if (exp_w.size() == 0) begin
            n_chk++;
            $display("FAIL unexpected_write: addr %0d data 0x%08h, no write expected",
                     bus.imem_addr, bus.imem_wdata);
          end else begin
            e = exp_w.pop_front();
            check("wr_addr", 32'(bus.imem_addr), e.addr);
            check("wr_data", bus.imem_wdata, e.data);
            check("wr_words_loaded", 32'(bus.words_loaded), 32'(e.wl));
            check("wr_cycle", 32'(cyc), 32'(acc_cyc[e.idx]));
          end
        end
        if (bus.done) begin
          done_cnt++;
          done_cyc = cyc;
          chk_idle = 1;
          if (exp_d.size() == 0) begin
            n_chk++;
            $display("FAIL unexpected_done: error %0b words_loaded %0d", bus.error, bus.words_loaded);
          end else begin
            d = exp_d.pop_front();
            check("done_error", 32'(bus.error), 32'(d.err));
            check("done_words_loaded", 32'(bus.words_loaded), 32'(d.wl));
            check("done_cycle", 32'(cyc), 32'(acc_cyc[d.idx]));
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic push_w(input logic [31:0] a, input logic [31:0] dat, input int wl, input int idx);
    wr_t e;
    e.addr = a; e.data = dat; e.wl = wl; e.idx = idx;
    exp_w.push_back(e);
  endtask

  task automatic push_d(input logic err, input int wl, input int idx);
    dn_t d;
    d.err = err; d.wl = wl; d.idx = idx;
    exp_d.push_back(d);
  endtask

  // Drive n bytes with s_valid held high; record the cycle each byte is taken.
  task automatic send(input logic [7:0] fr[$], input int n);
    for (int i = 0; i < n; i++) begin
      int waited;
      waited = 0;
      bus.s_valid = 1'b1;
      bus.s_data  = fr[i];
      @(negedge clk);
      while (!bus.s_ready && waited < 20) begin
        @(negedge clk);
        waited++;
      end
      if (!bus.s_ready) begin
        n_chk++;
        $display("FAIL stream_stall: byte %0d not accepted within 20 cycles", i);
        bus.s_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
      acc_cyc[i] = cyc;
    end
    bus.s_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int c0;
    int k;
    c0 = done_cnt;
    k  = 0;
    while (done_cnt == c0 && k < 100) begin
      tick();
      k++;
    end
    if (done_cnt == c0) begin
      n_chk++;
      $display("FAIL %s_timeout: done not seen within 100 cycles", name);
    end else begin
      tick();
    end
    check({name, "_writes_drained"}, 32'(exp_w.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_s_ready"},  32'(bus.s_ready), 32'd0);
    check({name, "_imem_we"},  32'(bus.imem_we), 32'd0);
    check({name, "_addr"},     32'(bus.imem_addr), 32'd0);
    check({name, "_wdata"},    bus.imem_wdata, 32'd0);
    check({name, "_hold"},     32'(bus.cpu_hold), 32'd0);
    check({name, "_busy"},     32'(bus.busy), 32'd0);
    check({name, "_done"},     32'(bus.done), 32'd0);
    check({name, "_error"},    32'(bus.error), 32'd0);
    check({name, "_wl"},       32'(bus.words_loaded), 32'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [7:0] f1[$];
    logic [7:0] f2[$];
    logic [7:0] f3[$];
    logic [7:0] f4[$];
    logic [7:0] f5[$];

    f1 = '{8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h12};
    f2 = '{8'h03, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'hA0, 8'h00,
           8'hB3, 8'h81, 8'h20, 8'h00, 8'h60};
    f3 = '{8'h03, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'hA0, 8'h00,
           8'hB3, 8'h81, 8'h20, 8'h00, 8'h61};
    f4 = '{8'h05, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
           8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F, 8'h10,
           8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h37};
    f5 = '{8'h00, 8'h00, 8'h00};

    bus.start   = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data  = 8'h00;

    // Reset state, held and just released.
    rst = 1'b1;
    repeat (3) tick();
    check_reset_outputs("rst_held");
    rst = 1'b0;
    tick();
    check_reset_outputs("rst_released");

    // s_valid while IDLE is not consumed.
    bus.s_valid = 1'b1;
    bus.s_data  = 8'hFF;
    repeat (3) tick();
    check("idle_valid_s_ready", 32'(bus.s_ready), 32'd0);
    check("idle_valid_busy", 32'(bus.busy), 32'd0);
    bus.s_valid = 1'b0;
    tick();

    // 1: single word.
    push_w(32'd0, 32'h0000_0013, 1, 5);
    push_d(1'b0, 1, 6);
    do_start();
    check("t1_hold_after_start", 32'(bus.cpu_hold), 32'd1);
    ready_gaps = 0;
    send(f1, 7);
    wait_done("t1");
    check("t1_no_gaps", 32'(ready_gaps), 32'd0);

    // 2: three words, correct checksum.
    push_w(32'd0, 32'h0050_0093, 1, 5);
    push_w(32'd1, 32'h00A0_0113, 2, 9);
    push_w(32'd2, 32'h0020_81B3, 3, 13);
    push_d(1'b0, 3, 14);
    do_start();
    ready_gaps = 0;
    send(f2, 15);
    wait_done("t2");
    check("t2_no_gaps", 32'(ready_gaps), 32'd0);

    // 3: bad checksum, words still written.
    push_w(32'd0, 32'h0050_0093, 1, 5);
    push_w(32'd1, 32'h00A0_0113, 2, 9);
    push_w(32'd2, 32'h0020_81B3, 3, 13);
    push_d(1'b1, 3, 14);
    do_start();
    send(f3, 15);
    wait_done("t3");
    check("t3_error_sticky", 32'(bus.error), 32'd1);

    // 4: five words into a 4-word memory.
    push_w(32'd0, 32'h0403_0201, 1, 5);
    push_w(32'd1, 32'h0807_0605, 2, 9);
    push_w(32'd2, 32'h0C0B_0A09, 3, 13);
    push_w(32'd3, 32'h100F_0E0D, 4, 17);
    push_d(1'b1, 4, 22);
    do_start();
    send(f4, 23);
    wait_done("t4");

    // 5: empty frame; start clears previous error.
    push_d(1'b0, 0, 2);
    do_start();
    check("t5_error_cleared", 32'(bus.error), 32'd0);
    send(f5, 3);
    wait_done("t5");
    check("t5_done_latency", 32'(done_cyc), 32'(start_cyc + 3));

    // 6: reset mid-load, then a clean reload.
    push_w(32'd0, 32'h0050_0093, 1, 5);
    do_start();
    send(f2, 8);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("t6_rst_mid");
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("t6_partial_drained", 32'(exp_w.size()), 32'd0);
    push_w(32'd0, 32'h0050_0093, 1, 5);
    push_w(32'd1, 32'h00A0_0113, 2, 9);
    push_w(32'd2, 32'h0020_81B3, 3, 13);
    push_d(1'b0, 3, 14);
    do_start();
    send(f2, 15);
    wait_done("t6");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
